// File: rtl/ws2812b_frame_sequencer_if.sv
// Pixel stream handshake between the frame sequencer and the ws2812b strip core.
// The sequencer drives data/valid/latch; the core answers with ready.
interface ws2812b_frame_sequencer_if;
  logic [23:0] strip_data;
  logic        strip_valid;
  logic        strip_latch;
  logic        strip_ready;

  modport master (
    output strip_data,
    output strip_valid,
    output strip_latch,
    input  strip_ready
  );

  modport slave (
    input  strip_data,
    input  strip_valid,
    input  strip_latch,
    output strip_ready
  );
endinterface

// File: rtl/ws2812b_frame_sequencer.sv
// Frame sequencer: buffers pixels, scales brightness and streams a frame
// to the ws2812b core, with optional timed auto-refresh.
module ws2812b_frame_sequencer #(
  parameter int NUM_PIXELS  = 16,
  parameter int IDX_W       = 4,
  parameter int REFRESH_GAP = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_addr,
  input  logic [23:0]           wr_data,
  input  logic                  start,
  input  logic [IDX_W:0]        frame_len,
  input  logic [7:0]            brightness,
  input  logic                  auto_refresh,
  ws2812b_frame_sequencer_if.master strip,
  output logic                  busy,
  output logic                  done,
  output logic [IDX_W-1:0]      pix_index
);

  localparam int GW = (REFRESH_GAP > 1) ? $clog2(REFRESH_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_GAP
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [23:0]      r_buf [NUM_PIXELS];
  logic [IDX_W:0]   r_len, w_len_nxt;
  logic [7:0]       r_bright, w_bright_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [23:0]      r_data, w_data_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_latch, w_latch_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [GW-1:0]    r_gap, w_gap_nxt;

  logic [IDX_W:0]   w_len_clamp;
  logic [23:0]      w_pix;
  logic [23:0]      w_scaled;
  logic             w_last;
  logic             w_xfer;
  logic             w_restart;

  function automatic logic [7:0] scale(
    input logic [7:0] c,
    input logic [7:0] b
  );
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, b} + 16'd1);
    return p[15:8];
  endfunction

  assign w_len_clamp =
    (frame_len > (IDX_W+1)'(NUM_PIXELS)) ?
    (IDX_W+1)'(NUM_PIXELS) : frame_len;

  assign w_pix    = r_buf[r_idx];
  assign w_scaled = {scale(w_pix[23:16], r_bright),
                     scale(w_pix[15:8],  r_bright),
                     scale(w_pix[7:0],   r_bright)};
  assign w_last   = ({1'b0, r_idx} == (r_len - (IDX_W+1)'(1)));
  assign w_xfer   = r_valid & strip.strip_ready;

  // start is only honoured when idle or waiting out the refresh gap
  assign w_restart = start &
    ((r_state == S_IDLE) | (r_state == S_GAP));

  always_ff @(posedge clk) begin
    if (wr_en)
      r_buf[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_len_nxt    = r_len;
    w_bright_nxt = r_bright;
    w_idx_nxt    = r_idx;
    w_data_nxt   = r_data;
    w_valid_nxt  = r_valid;
    w_latch_nxt  = r_latch;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_gap_nxt    = r_gap;
    if (w_restart) begin
      w_len_nxt    = w_len_clamp;
      w_bright_nxt = brightness;
      w_idx_nxt    = '0;
      if (w_len_clamp == '0) begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
      end else begin
        w_state_nxt = S_LOAD;
        w_busy_nxt  = 1'b1;
      end
    end else begin
      unique case (r_state)
        S_IDLE: ;
        S_LOAD: begin
          w_data_nxt  = w_scaled;
          w_latch_nxt = w_last;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_SEND;
        end
        S_SEND: begin
          if (w_xfer) begin
            w_valid_nxt = 1'b0;
            w_latch_nxt = 1'b0;
            w_done_nxt  = w_last;
            w_state_nxt = S_WAIT_LOW;
          end
        end
        S_WAIT_LOW: begin
          if (!strip.strip_ready)
            w_state_nxt = S_WAIT_HIGH;
        end
        S_WAIT_HIGH: begin
          if (strip.strip_ready) begin
            if (!w_last) begin
              w_idx_nxt   = r_idx + 1'b1;
              w_state_nxt = S_LOAD;
            end else if (auto_refresh) begin
              w_gap_nxt   = '0;
              w_state_nxt = S_GAP;
            end else begin
              w_busy_nxt  = 1'b0;
              w_state_nxt = S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (!auto_refresh) begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end else if (r_gap == GW'(REFRESH_GAP - 1)) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_LOAD;
          end else begin
            w_gap_nxt = r_gap + 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len    <= '0;
      r_bright <= '0;
      r_idx    <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_latch  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_gap    <= '0;
    end else begin
      r_len    <= w_len_nxt;
      r_bright <= w_bright_nxt;
      r_idx    <= w_idx_nxt;
      r_data   <= w_data_nxt;
      r_valid  <= w_valid_nxt;
      r_latch  <= w_latch_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_gap    <= w_gap_nxt;
    end
  end

  assign strip.strip_data  = r_data;
  assign strip.strip_valid = r_valid;
  assign strip.strip_latch = r_latch;
  assign busy              = r_busy;
  assign done              = r_done;
  assign pix_index         = r_idx;

endmodule
